// File: rtl/jk_excitation_driver_pkg.sv
// Shared encodings for the JK excitation driver: FSM states, JK drive codes,
// and the retry-counter width helper.
package jk_excitation_driver_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DRIVE = 2'd1;
   localparam logic [1:0] ST_CHECK = 2'd2;

   // {J,K} drive codes
   localparam logic [1:0] JK_HOLD = 2'b00;
   localparam logic [1:0] JK_RST  = 2'b01;
   localparam logic [1:0] JK_SET  = 2'b10;
   localparam logic [1:0] JK_TGL  = 2'b11;

   function automatic int unsigned retry_cnt_w(input int unsigned max_retry);
      return (max_retry > 0) ? $clog2(max_retry + 1) : 1;
   endfunction

endpackage

// File: rtl/jk_exc_encode.sv
// Per-word JK excitation: maps current flop state q and desired state d to J/K.
// Unchanged bits always get HOLD so the bank never sees a stray pulse.
module jk_exc_encode
   import jk_excitation_driver_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_q,
   input  logic [WIDTH-1:0] i_d,
   input  logic             i_use_toggle,
   output logic [WIDTH-1:0] o_j,
   output logic [WIDTH-1:0] o_k
);

   logic [1:0] w_code;

   always_comb begin
      o_j    = '0;
      o_k    = '0;
      w_code = JK_HOLD;
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (i_q[i] == i_d[i])
            w_code = JK_HOLD;
         else if (i_use_toggle)
            w_code = JK_TGL;
         else if (i_d[i])
            w_code = JK_SET;
         else
            w_code = JK_RST;
         o_j[i] = w_code[1];
         o_k[i] = w_code[0];
      end
   end

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives an external JK flop bank toward a target word, verifies the result
// through q feedback and re-drives on mismatch up to MAX_RETRY times.
//
//  state    | meaning
//  ST_IDLE  | ready for a target; j=k=0; done/err pulse cycle
//  ST_DRIVE | j/k asserted for exactly one cycle; bank updates at exit edge
//  ST_CHECK | j=k=0; q_fb compared to latched target
module jk_excitation_driver
   import jk_excitation_driver_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned MAX_RETRY  = 3,
   parameter bit          USE_TOGGLE = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_tgt_valid,
   input  logic [WIDTH-1:0] i_tgt_data,
   output logic             o_tgt_ready,
   input  logic [WIDTH-1:0] i_q_fb,
   output logic [WIDTH-1:0] o_j,
   output logic [WIDTH-1:0] o_k,
   output logic             o_done,
   output logic             o_err,
   output logic [WIDTH-1:0] o_mismatch
);

   localparam int unsigned      CNT_W   = retry_cnt_w(MAX_RETRY);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_RETRY);

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_tgt;
   logic [WIDTH-1:0] r_j;
   logic [WIDTH-1:0] r_k;
   logic [WIDTH-1:0] r_mismatch;
   logic [CNT_W-1:0] r_cnt;
   logic             r_done;
   logic             r_err;

   logic [WIDTH-1:0] w_enc_d;
   logic [WIDTH-1:0] w_enc_j;
   logic [WIDTH-1:0] w_enc_k;
   logic             w_match;

   // In IDLE the encoder sees the incoming word; on retries it sees the latched one.
   assign w_enc_d = (r_state == ST_IDLE) ? i_tgt_data : r_tgt;
   // An X on q_fb makes this unknown, which falls to the mismatch branch below.
   assign w_match = (i_q_fb == r_tgt);

   jk_exc_encode #(.WIDTH(WIDTH)) u_encode (
      .i_q          (i_q_fb),
      .i_d          (w_enc_d),
      .i_use_toggle (USE_TOGGLE),
      .o_j          (w_enc_j),
      .o_k          (w_enc_k)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_tgt      <= '0;
         r_j        <= '0;
         r_k        <= '0;
         r_mismatch <= '0;
         r_cnt      <= '0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_tgt_valid) begin
                  r_tgt      <= i_tgt_data;
                  r_cnt      <= '0;
                  r_mismatch <= '0;
                  r_j        <= w_enc_j;
                  r_k        <= w_enc_k;
                  r_state    <= ST_DRIVE;
               end
            end
            ST_DRIVE: begin
               r_j     <= '0;
               r_k     <= '0;
               r_state <= ST_CHECK;
            end
            ST_CHECK: begin
               if (w_match) begin
                  r_done  <= 1'b1;
                  r_state <= ST_IDLE;
               end else if (r_cnt < CNT_MAX) begin
                  r_cnt   <= r_cnt + 1'b1;
                  r_j     <= w_enc_j;
                  r_k     <= w_enc_k;
                  r_state <= ST_DRIVE;
               end else begin
                  r_err      <= 1'b1;
                  r_mismatch <= i_q_fb ^ r_tgt;
                  r_state    <= ST_IDLE;
               end
            end
            default: begin
               r_j     <= '0;
               r_k     <= '0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_tgt_ready = (r_state == ST_IDLE);
   assign o_j         = r_j;
   assign o_k         = r_k;
   assign o_done      = r_done;
   assign o_err       = r_err;
   assign o_mismatch  = r_mismatch;

endmodule
